magnetron_power_ctrl: RTL
=========================

Name: magnetron_power_ctrl

Overview:
Clocked, parametrised successor to the latch-based magnetron enable. It owns the full cook cycle: start, stop/pause, resume, clear, countdown timer, door interlock, and a power-level duty cycle in place of plain on/off. It sits between the front-panel/door inputs and the magnetron driver. It drives the time display and the end-of-cook beeper.

Parameters:
TIME_W, 16, width of seconds counter (max cook time 2^TIME_W-1 s)
POWER_LEVELS, 10, duty window length in ticks; also max power level
LVL_W, 4, width of power_level input (must hold POWER_LEVELS)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
startn  in  1  start button, active-low, pre-synchronised level
stopn  in  1  stop/pause button, active-low level
clearn  in  1  clear/cancel button, active-low level
door_closed  in  1  door switch, 1 = closed
tick  in  1  one-cycle strobe, 1 Hz time base
time_load  in  TIME_W  cook time in seconds, sampled on start from IDLE
power_level  in  LVL_W  requested power 0..POWER_LEVELS, sampled on start and resume
magnetron_on  out  1  magnetron drive
remaining  out  TIME_W  seconds left
state  out  2  0=IDLE 1=COOK 2=PAUSED 3=DONE
done  out  1  one-cycle pulse on COOK->DONE

Behaviour:
- Reset: state=IDLE; remaining=0; done=0; magnetron_on=0; duty_cnt=0; lvl_q=0; startn_q=1.
- start_evt = startn_q & ~startn (registered falling edge). A held button gives one event only.
- Event priority, every state: ~clearn > ~door_closed > ~stopn > start_evt > tick.
- IDLE:
  - start_evt & door_closed & time_load!=0 -> COOK; remaining<=time_load; lvl_q<=sat(power_level); duty_cnt<=0.
  - time_load==0 or door open: start ignored.
- COOK:
  - ~clearn -> IDLE, remaining<=0.
  - ~door_closed or ~stopn -> PAUSED; remaining holds; a tick in the same cycle is dropped.
  - Otherwise on tick:
    - remaining==1 -> DONE, remaining<=0, done=1 for one cycle.
    - else remaining<=remaining-1.
    - duty_cnt<=(duty_cnt==POWER_LEVELS-1)?0:duty_cnt+1.
- PAUSED:
  - ~clearn -> IDLE, remaining<=0.
  - start_evt & door_closed -> COOK; lvl_q<=sat(power_level); duty_cnt<=0; remaining unchanged.
  - Ticks ignored.
- DONE:
  - ~clearn, start_evt, or door opening -> IDLE.
  - remaining stays 0.
- sat(x) = min(x, POWER_LEVELS). Level 0 means the timer runs with the magnetron never on.
- magnetron_on = (state==COOK) & (duty_cnt < lvl_q) & door_closed & stopn & clearn.
  - The last three terms are combinational, so the interlock cuts the drive the same cycle the door opens or a button is pressed. Registered state follows next edge.
- Full power (lvl_q==POWER_LEVELS): on continuously in COOK.
- Ticks affect only COOK. remaining never underflows or wraps.
- rst mid-cook: IDLE next edge, magnetron_on=0 from that edge.

Test Plan:
1. time_load=5, power_level=10, door closed, press start, 5 ticks -> magnetron_on=1 throughout COOK; remaining 5,4,3,2,1,0; done pulses once; state=DONE; magnetron_on=0.
2. power_level=3, time_load=20, start, 20 ticks -> magnetron_on high for duty_cnt 0..2 of each 10-tick window: 6 ticks on, 14 off.
3. time_load=10, start, 4 ticks, door opens while tick=1 -> magnetron_on=0 same cycle; state=PAUSED; remaining=6. Close door, start -> COOK, remaining continues 6->5.
4. Hold startn low 50 cycles in IDLE, time_load=8 -> exactly one COOK entry. In COOK, stopn and clearn low together -> IDLE, remaining=0.
5. Start with door open or time_load=0 -> stays IDLE, magnetron_on=0. power_level=15 -> behaves as 10. power_level=0 -> timer counts, magnetron_on never 1.
6. Assert rst in COOK with remaining=7 -> next edge state=IDLE, remaining=0, magnetron_on=0, done=0.

Source files
------------

// File: rtl/magnetron_power_ctrl.sv
// Magnetron cook-cycle controller: start/pause/resume/clear,
// countdown timer, door interlock and duty-cycled power level.
module magnetron_power_ctrl #(
  parameter int TIME_W       = 16,
  parameter int POWER_LEVELS = 10,
  parameter int LVL_W        = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              startn,
  input  logic              stopn,
  input  logic              clearn,
  input  logic              door_closed,
  input  logic              tick,
  input  logic [TIME_W-1:0] time_load,
  input  logic [LVL_W-1:0]  power_level,
  output logic              magnetron_on,
  output logic [TIME_W-1:0] remaining,
  output logic [1:0]        state,
  output logic              done
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_COOK   = 2'd1;
  localparam logic [1:0] S_PAUSED = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam logic [LVL_W-1:0] LVL_MAX =
    LVL_W'(POWER_LEVELS);
  localparam logic [LVL_W-1:0] DUTY_LAST =
    LVL_W'(POWER_LEVELS - 1);
  localparam logic [TIME_W-1:0] TIME_ONE =
    TIME_W'(1);

  logic              startn_q;
  logic [LVL_W-1:0]  lvl_q;
  logic [LVL_W-1:0]  duty_cnt;

  logic [1:0]        state_d;
  logic [TIME_W-1:0] rem_d;
  logic [LVL_W-1:0]  lvl_d;
  logic [LVL_W-1:0]  duty_d;
  logic              done_d;

  logic              start_evt;
  logic              clr;
  logic              door_open;
  logic              stop;
  logic              hold;
  logic [LVL_W-1:0]  lvl_sat;
  logic              time_zero;
  logic              rem_last;
  logic [LVL_W-1:0]  duty_next;

  assign start_evt = startn_q & ~startn;
  assign clr       = ~clearn;
  assign door_open = ~door_closed;
  assign stop      = ~stopn;
  assign hold      = door_open | stop;
  assign time_zero = (time_load == '0);
  // A zero count cannot occur in COOK, but treat
  // it like the last second so it can never wrap.
  assign rem_last  = (remaining <= TIME_ONE);

  // Clamp requested level to the duty window length.
  assign lvl_sat = (power_level > LVL_MAX) ?
                   LVL_MAX : power_level;

  // Duty counter wraps at the end of each window.
  assign duty_next = (duty_cnt == DUTY_LAST) ?
                     '0 : duty_cnt + 1'b1;

  // Next-state and datapath decode with fixed
  // event priority: clear, door, stop, start, tick.
  always_comb begin
    state_d = state;
    rem_d   = remaining;
    lvl_d   = lvl_q;
    duty_d  = duty_cnt;
    done_d  = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (!clr && !hold && start_evt &&
            !time_zero) begin
          state_d = S_COOK;
          rem_d   = time_load;
          lvl_d   = lvl_sat;
          duty_d  = '0;
        end
      end
      S_COOK: begin
        if (clr) begin
          state_d = S_IDLE;
          rem_d   = '0;
        end else if (hold) begin
          state_d = S_PAUSED;
        end else if (tick) begin
          if (rem_last) begin
            state_d = S_DONE;
            rem_d   = '0;
            done_d  = 1'b1;
            duty_d  = '0;
          end else begin
            rem_d  = remaining - TIME_ONE;
            duty_d = duty_next;
          end
        end
      end
      S_PAUSED: begin
        if (clr) begin
          state_d = S_IDLE;
          rem_d   = '0;
        end else if (!hold && start_evt) begin
          state_d = S_COOK;
          lvl_d   = lvl_sat;
          duty_d  = '0;
        end
      end
      S_DONE: begin
        rem_d = '0;
        if (clr || door_open || start_evt) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        rem_d   = '0;
      end
    endcase
  end

  // Registered controller state with sync reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      remaining <= '0;
      done      <= 1'b0;
      duty_cnt  <= '0;
      lvl_q     <= '0;
      startn_q  <= 1'b1;
    end else begin
      state     <= state_d;
      remaining <= rem_d;
      done      <= done_d;
      duty_cnt  <= duty_d;
      lvl_q     <= lvl_d;
      startn_q  <= startn;
    end
  end

  // Interlock terms are combinational so the drive
  // drops in the same cycle the door or a button acts.
  always_comb begin
    magnetron_on = (state == S_COOK) &
                   (duty_cnt < lvl_q) &
                   door_closed & stopn & clearn;
  end

endmodule
